// File: rtl/seg_scroll_pkg.sv
// seg_scroll_pkg: shared character codes, segment patterns and scroll constants
// for the seven-segment scrolling-message engine.
package seg_scroll_pkg;

    // Character codes held in the message buffer
    localparam logic [3:0] CH_0     = 4'h0;
    localparam logic [3:0] CH_1     = 4'h1;
    localparam logic [3:0] CH_2     = 4'h2;
    localparam logic [3:0] CH_3     = 4'h3;
    localparam logic [3:0] CH_4     = 4'h4;
    localparam logic [3:0] CH_5     = 4'h5;
    localparam logic [3:0] CH_6     = 4'h6;
    localparam logic [3:0] CH_7     = 4'h7;
    localparam logic [3:0] CH_8     = 4'h8;
    localparam logic [3:0] CH_9     = 4'h9;
    localparam logic [3:0] CH_A     = 4'hA;
    localparam logic [3:0] CH_B     = 4'hB;
    localparam logic [3:0] CH_G     = 4'hC;
    localparam logic [3:0] CH_U     = 4'hD;
    localparam logic [3:0] CH_F     = 4'hE;
    localparam logic [3:0] CH_BLANK = 4'hF;

    // Active-low segment patterns, bit order {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_A     = 7'h08;
    localparam logic [6:0] SEG_B     = 7'h03;
    localparam logic [6:0] SEG_G     = 7'h42;
    localparam logic [6:0] SEG_U     = 7'h41;
    localparam logic [6:0] SEG_F     = 7'h0E;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // "GO BUFFS": character k sits at bits [4k+3:4k], so buffer index 0 is 'G'
    localparam logic [31:0] MSG_GO_BUFFS = {CH_5, CH_F, CH_F, CH_U,
                                            CH_B, CH_BLANK, CH_0, CH_G};

    // Scroll direction encoding (input dir and the bounce-mode register)
    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_RIGHT = 1'b1;

endpackage

// File: rtl/seg_decode.sv
// seg_decode: combinational character-code to active-low seven-segment decoder.
module seg_decode
    import seg_scroll_pkg::*;
(
    input  logic [3:0] code,
    output logic [6:0] seg
);

    // Map each 4-bit character code to its segment pattern
    always_comb begin
        seg = SEG_BLANK;
        case (code)
            CH_0:     seg = SEG_0;
            CH_1:     seg = SEG_1;
            CH_2:     seg = SEG_2;
            CH_3:     seg = SEG_3;
            CH_4:     seg = SEG_4;
            CH_5:     seg = SEG_5;
            CH_6:     seg = SEG_6;
            CH_7:     seg = SEG_7;
            CH_8:     seg = SEG_8;
            CH_9:     seg = SEG_9;
            CH_A:     seg = SEG_A;
            CH_B:     seg = SEG_B;
            CH_G:     seg = SEG_G;
            CH_U:     seg = SEG_U;
            CH_F:     seg = SEG_F;
            default:  seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/seg_scroll.sv
// seg_scroll: scrolling-message engine for a seven-segment bank.
// Internal step prescaler, writable message buffer, run/stop, direction,
// single-step and a wrap pulse. seg is registered and active-low.
// Optional build macro SEG_SCROLL_BOUNCE_EN selects ping-pong scrolling
// (dir input ignored, offset bounces between 0 and MSG_LEN-NUM_DIGITS).
module seg_scroll
    import seg_scroll_pkg::*;
#(
    parameter int unsigned NUM_DIGITS = 6,
    parameter int unsigned MSG_LEN    = 16,
    parameter int unsigned TICK_DIV   = 12_500_000
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        run,
    input  logic                        dir,
    input  logic                        step,
    input  logic                        wr_en,
    input  logic [$clog2(MSG_LEN)-1:0]  wr_addr,
    input  logic [3:0]                  wr_data,
    output logic [NUM_DIGITS*7-1:0]     seg,
    output logic [$clog2(MSG_LEN)-1:0]  pos,
    output logic                        wrap
);

    localparam int unsigned AW = $clog2(MSG_LEN);
    localparam int unsigned CW = $clog2(TICK_DIV);

    localparam logic [CW-1:0] CNT_LAST = CW'(TICK_DIV - 1);
    localparam logic [AW-1:0] OFF_LAST = AW'(MSG_LEN - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          tick;
    logic          advance;

    logic [AW-1:0] offset_q, offset_d;
    logic          wrap_q, wrap_d;

    logic [3:0]    msg_q [MSG_LEN];
    logic          addr_ok;

    logic [NUM_DIGITS*7-1:0] seg_d, seg_q;

    // ------------------------------------------------------------------
    // Prescaler
    // ------------------------------------------------------------------

    // Count 0..TICK_DIV-1 while running; held at 0 when stopped
    always_comb begin
        tick  = run && (cnt_q == CNT_LAST);
        cnt_d = cnt_q;
        if (!run || tick) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    // Prescaler state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // step only counts while stopped; the tick schedule owns motion otherwise
    assign advance = run ? tick : step;

    // ------------------------------------------------------------------
    // Offset sequencing
    // ------------------------------------------------------------------

`ifdef SEG_SCROLL_BOUNCE_EN
    localparam logic [AW-1:0] OFF_MAX = AW'(MSG_LEN - NUM_DIGITS);

    logic dir_q, dir_d;
    logic unused_dir;

    assign unused_dir = dir;

    // Ping-pong between 0 and OFF_MAX, reversing (and pulsing wrap) at each end
    always_comb begin
        offset_d = offset_q;
        dir_d    = dir_q;
        wrap_d   = 1'b0;
        if (advance) begin
            if (OFF_MAX == '0) begin
                // Message exactly fills the display: nothing to scroll
                wrap_d = 1'b1;
            end else if (dir_q == DIR_LEFT) begin
                offset_d = offset_q + AW'(1);
                if (offset_d == OFF_MAX) begin
                    dir_d  = DIR_RIGHT;
                    wrap_d = 1'b1;
                end
            end else begin
                offset_d = offset_q - AW'(1);
                if (offset_d == '0) begin
                    dir_d  = DIR_LEFT;
                    wrap_d = 1'b1;
                end
            end
        end
    end

    // Bounce direction register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dir_q <= DIR_LEFT;
        end else begin
            dir_q <= dir_d;
        end
    end
`else
    // Circular offset: step by one in the requested direction, wrapping at the ends
    always_comb begin
        offset_d = offset_q;
        wrap_d   = 1'b0;
        if (advance) begin
            if (dir == DIR_LEFT) begin
                if (offset_q == OFF_LAST) begin
                    offset_d = '0;
                    wrap_d   = 1'b1;
                end else begin
                    offset_d = offset_q + AW'(1);
                end
            end else begin
                if (offset_q == '0) begin
                    offset_d = OFF_LAST;
                    wrap_d   = 1'b1;
                end else begin
                    offset_d = offset_q - AW'(1);
                end
            end
        end
    end
`endif

    // Offset and wrap registers; wrap lands on the same edge as the new offset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            offset_q <= '0;
            wrap_q   <= 1'b0;
        end else begin
            offset_q <= offset_d;
            wrap_q   <= wrap_d;
        end
    end

    // ------------------------------------------------------------------
    // Message buffer
    // ------------------------------------------------------------------

    // Out-of-range addresses only exist when MSG_LEN is not a power of two
    if ((1 << AW) == MSG_LEN) begin : g_addr_full
        assign addr_ok = 1'b1;
    end else begin : g_addr_part
        assign addr_ok = (wr_addr < AW'(MSG_LEN));
    end

    // Buffer writes; independent of advances so both can happen in one cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < int'(MSG_LEN); k++) begin
                msg_q[k] <= CH_BLANK;
            end
        end else if (wr_en && addr_ok) begin
            msg_q[wr_addr] <= wr_data;
        end
    end

    // ------------------------------------------------------------------
    // Display mapping
    // ------------------------------------------------------------------

    for (genvar g = 0; g < int'(NUM_DIGITS); g++) begin : g_digit
        logic [AW:0]   sum;
        logic [AW-1:0] idx;
        logic [3:0]    code;

        // Buffer index for this digit; sum < 2*MSG_LEN so one subtract reduces it
        always_comb begin
            sum = {1'b0, offset_q} + (AW+1)'(NUM_DIGITS - 1 - g);
            if (sum >= (AW+1)'(MSG_LEN)) begin
                sum = sum - (AW+1)'(MSG_LEN);
            end
        end

        assign idx  = sum[AW-1:0];
        assign code = msg_q[idx];

        seg_decode u_dec (
            .code (code),
            .seg  (seg_d[7*g +: 7])
        );
    end

    // Registered segment outputs; reset shows a blank bank
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seg_q <= '1;
        end else begin
            seg_q <= seg_d;
        end
    end

    assign seg  = seg_q;
    assign pos  = offset_q;
    assign wrap = wrap_q;

endmodule

// File: tb/tb_seg_scroll.sv
// tb_seg_scroll: self-checking bench for seg_scroll (NUM_DIGITS=6, MSG_LEN=8, TICK_DIV=4).
module tb_seg_scroll;
    import seg_scroll_pkg::*;

    localparam int N  = 6;
    localparam int L  = 8;
    localparam int T  = 4;
    localparam int AW = 3;

    logic             clk = 1'b0;
    logic             rst;
    logic             run, dir, step, wr_en;
    logic [AW-1:0]    wr_addr;
    logic [3:0]       wr_data;
    logic [N*7-1:0]   seg;
    logic [AW-1:0]    pos;
    logic             wrap;

    always #5 clk = ~clk;

    seg_scroll #(
        .NUM_DIGITS (N),
        .MSG_LEN    (L),
        .TICK_DIV   (T)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .run     (run),
        .dir     (dir),
        .step    (step),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .seg     (seg),
        .pos     (pos),
        .wrap    (wrap)
    );

    // Bench's own font, indexed by character code
    logic [6:0] font [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                              7'h00, 7'h10, 7'h08, 7'h03, 7'h42, 7'h41, 7'h0E, 7'h7F};

    // Reference model state
    int         m_off, m_cnt, m_dir;
    logic [3:0] m_msg [L];

    int n_checks = 0;
    int n_errors = 0;
    int wraps_seen = 0;
    bit auto_chk = 1'b0;

    typedef struct {
        logic [3:0] code;
        logic [6:0] exp_seg;
    } vec_t;
    vec_t vecs [16];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_off = 0;
        m_cnt = 0;
        m_dir = 0;
        for (int k = 0; k < L; k++) m_msg[k] = 4'hF;
    endtask

    function automatic logic [N*7-1:0] model_seg();
        logic [N*7-1:0] s;
        for (int i = 0; i < N; i++) s[7*i +: 7] = font[m_msg[(m_off + N - 1 - i) % L]];
        return s;
    endfunction

    // Advance the model across one rising edge, then compare the DUT just after it
    task automatic tick_clk();
        logic [N*7-1:0] exp_seg;
        bit adv;
        bit m_wrap;
        m_wrap  = 1'b0;
        exp_seg = model_seg();
        if (rst) begin
            model_reset();
            exp_seg = '1;
        end else begin
            adv   = run ? (m_cnt == T - 1) : step;
            m_cnt = run ? (m_cnt + 1) % T : 0;
            if (adv) begin
`ifdef SEG_SCROLL_BOUNCE_EN
                if (m_dir == 0) begin
                    m_off++;
                    if (m_off == L - N) begin m_dir = 1; m_wrap = 1'b1; end
                end else begin
                    m_off--;
                    if (m_off == 0) begin m_dir = 0; m_wrap = 1'b1; end
                end
`else
                if (dir == 1'b0) begin
                    m_wrap = (m_off == L - 1);
                    m_off  = (m_off + 1) % L;
                end else begin
                    m_wrap = (m_off == 0);
                    m_off  = (m_off + L - 1) % L;
                end
`endif
            end
            if (wr_en && int'(wr_addr) < L) m_msg[wr_addr] = wr_data;
        end
        @(posedge clk);
        #1;
        if (wrap) wraps_seen++;
        if (auto_chk) begin
            check("model_seg", 64'(seg), 64'(exp_seg));
            check("model_pos", 64'(pos), 64'(m_off));
            check("model_wrap", 64'(wrap), 64'(m_wrap));
        end
    endtask

    initial begin
        logic [31:0] gb;
        int p;
        rst = 1'b1; run = 1'b0; dir = 1'b0; step = 1'b0;
        wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        model_reset();

        vecs[0]  = '{4'h0, 7'h40}; vecs[1]  = '{4'h1, 7'h79};
        vecs[2]  = '{4'h2, 7'h24}; vecs[3]  = '{4'h3, 7'h30};
        vecs[4]  = '{4'h4, 7'h19}; vecs[5]  = '{4'h5, 7'h12};
        vecs[6]  = '{4'h6, 7'h02}; vecs[7]  = '{4'h7, 7'h78};
        vecs[8]  = '{4'h8, 7'h00}; vecs[9]  = '{4'h9, 7'h10};
        vecs[10] = '{4'hA, 7'h08}; vecs[11] = '{4'hB, 7'h03};
        vecs[12] = '{4'hC, 7'h42}; vecs[13] = '{4'hD, 7'h41};
        vecs[14] = '{4'hE, 7'h0E}; vecs[15] = '{4'hF, 7'h7F};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("reset_seg", 64'(seg), {22'd0, 42'h3FF_FFFF_FFFF});
        check("reset_pos", 64'(pos), 64'd0);
        check("reset_wrap", 64'(wrap), 64'd0);
        rst = 1'b0;
        auto_chk = 1'b1;

`ifndef SEG_SCROLL_BOUNCE_EN
        // Font table: HEX0 shows buffer index 5 at offset 0
        for (int v = 0; v < 16; v++) begin
            wr_en = 1'b1; wr_addr = 3'd5; wr_data = vecs[v].code;
            tick_clk();
            wr_en = 1'b0;
            tick_clk();
            check($sformatf("font_%0h", vecs[v].code), 64'(seg[6:0]), 64'(vecs[v].exp_seg));
        end

        // Load "GO BUFFS"
        gb = MSG_GO_BUFFS;
        for (int k = 0; k < L; k++) begin
            wr_en = 1'b1; wr_addr = AW'(k); wr_data = gb[4*k +: 4];
            tick_clk();
        end
        wr_en = 1'b0;
        tick_clk();
        check("go_buffs_seg", 64'(seg),
              64'({7'h42, 7'h40, 7'h7F, 7'h03, 7'h41, 7'h0E}));

        // Auto-scroll one full lap: exactly one wrap, back at 0
        wraps_seen = 0;
        run = 1'b1;
        repeat (4 * L) tick_clk();
        run = 1'b0;
        check("lap_wrap_count", 64'(wraps_seen), 64'd1);
        check("lap_pos", 64'(pos), 64'd0);

        // Reverse from 0: wraps to 7, HEX5 then shows '5'
        run = 1'b1; dir = 1'b1;
        repeat (T) tick_clk();
        check("rev_pos", 64'(pos), 64'd7);
        check("rev_wrap", 64'(wrap), 64'd1);
        run = 1'b0;
        tick_clk();
        check("rev_hex5", 64'(seg[41:35]), 64'h12);

        // Manual stepping
        dir = 1'b0;
        step = 1'b1; tick_clk(); step = 1'b0; tick_clk();
        for (int k = 0; k < 3; k++) begin
            step = 1'b1; tick_clk(); step = 1'b0; tick_clk();
        end
        check("step_pos", 64'(pos), 64'd3);
        run = 1'b1; step = 1'b1;
        repeat (T - 1) tick_clk();
        check("step_while_run", 64'(pos), 64'd3);
        step = 1'b0;
        tick_clk();
        check("run_after_step", 64'(pos), 64'd4);
        run = 1'b0;

        // Write and advance in the same cycle; written cell lands under HEX0
        p = int'(pos);
        step = 1'b1; wr_en = 1'b1; wr_addr = AW'((p + N) % L); wr_data = CH_8;
        tick_clk();
        step = 1'b0; wr_en = 1'b0;
        check("collide_pos", 64'(pos), 64'((p + 1) % L));
        tick_clk();
        check("collide_hex0", 64'(seg[6:0]), 64'h00);
`else
        // Bounce: 0,1,2,1,0,1 with wrap at both ends
        begin
            int exp_pos [6] = '{1, 2, 1, 0, 1, 2};
            bit exp_wr  [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
            for (int k = 0; k < 6; k++) begin
                step = 1'b1; tick_clk();
                check($sformatf("bounce_pos_%0d", k), 64'(pos), 64'(exp_pos[k]));
                check($sformatf("bounce_wrap_%0d", k), 64'(wrap), 64'(exp_wr[k]));
                step = 1'b0; tick_clk();
            end
        end
`endif

        // Randomized traffic against the model, with one asynchronous reset
        for (int i = 0; i < 400; i++) begin
            if (i % 16 == 0) begin
                run = ($urandom_range(0, 2) != 0);
                dir = 1'($urandom_range(0, 1));
            end
            step    = ($urandom_range(0, 3) == 0);
            wr_en   = ($urandom_range(0, 3) == 0);
            wr_addr = AW'($urandom_range(0, L - 1));
            wr_data = 4'($urandom_range(0, 15));
            if (i == 200) begin
                rst = 1'b1;
                #1;
                check("async_rst_pos", 64'(pos), 64'd0);
                check("async_rst_wrap", 64'(wrap), 64'd0);
                check("async_rst_seg", 64'(seg), {22'd0, 42'h3FF_FFFF_FFFF});
                tick_clk();
                rst = 1'b0;
            end else begin
                tick_clk();
            end
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
